// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit at a run-time bit width,
// and emits each byte as a one-cycle valid pulse (or a frame-error pulse).
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] uart_bit_width,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_data_vld,
    output logic        rx_frame_err,
    output logic        rx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;
    logic                   fall;

    logic [15:0] bw_q;
    logic [15:0] width_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;

    logic bit_end;
    logic half_hit;
    logic load_bw;
    logic shift_en;
    logic good;
    logic bad;

    // Flops preset to 1 so reset looks like an idle line, not a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall     = rx_s_d & ~rx_s;
    assign bit_end  = (width_cnt == bw_q);
    assign half_hit = (width_cnt == (bw_q >> 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_bw  = 1'b0;
        shift_en = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    load_bw = 1'b1;
                end
            end
            START: begin
                // High at mid start bit means it was a glitch
                if (half_hit) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    good    = rx_s;
                    bad     = ~rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bw_q      <= 16'd0;
            width_cnt <= 16'd0;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
        end else begin
            if (load_bw) begin
                bw_q <= uart_bit_width;
            end
            if (state_d != state_q || bit_end || state_q == IDLE) begin
                width_cnt <= 16'd0;
            end else begin
                width_cnt <= width_cnt + 16'd1;
            end
            if (state_d != DATA) begin
                bit_cnt <= 4'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data      <= 8'h00;
            rx_data_vld  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_data_vld  <= good;
            rx_frame_err <= bad;
            if (good) begin
                rx_data <= shift_reg;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back, break, glitch, reset and width-change cases.
module tb_uart_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] uart_bit_width;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_data_vld;
    logic        rx_frame_err;
    logic        rx_busy;

    uart_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_bit_width (uart_bit_width),
        .rx             (rx),
        .rx_data        (rx_data),
        .rx_data_vld    (rx_data_vld),
        .rx_frame_err   (rx_frame_err),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_start;
    int t_vld;
    int vld_cnt  = 0;
    int err_cnt  = 0;
    int viol_cnt = 0;
    logic busy_seen = 1'b0;
    logic prev_pulse = 1'b0;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: outputs change on posedge, sampled on negedge
    always @(negedge clk) begin
        if (rx_data_vld) begin
            vld_cnt++;
            t_vld = cyc;
            rxq.push_back(rx_data);
        end
        if (rx_frame_err) err_cnt++;
        if (rx_data_vld && rx_frame_err) viol_cnt++;
        if (prev_pulse && (rx_data_vld || rx_frame_err)) viol_cnt++;
        prev_pulse = rx_data_vld | rx_frame_err;
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p,
                              input logic stop_bit);
        rx = 1'b0;
        t_start = cyc;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (p) @(negedge clk);
        end
        rx = stop_bit;
        repeat (p) @(negedge clk);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [15:0] bw;
        logic [7:0]  data;
        logic        stop_bit;
        int          exp_vld;
        int          exp_err;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, e0, p, lat, bad_data;

        vecs[0] = '{16'd15, 8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{16'd15, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{16'd15, 8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{16'd7,  8'h81, 1'b1, 1, 0, 8'h81};
        vecs[4] = '{16'd3,  8'h7E, 1'b1, 1, 0, 8'h7E};
        vecs[5] = '{16'd15, 8'h3C, 1'b0, 0, 1, 8'h7E};

        rst = 1'b1;
        rx = 1'b1;
        uart_bit_width = 16'd15;
        repeat (3) @(negedge clk);
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset vld", int'(rx_data_vld), 0);
        chk("reset err", int'(rx_frame_err), 0);
        chk("reset busy", int'(rx_busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table of single frames
        foreach (vecs[k]) begin
            uart_bit_width = vecs[k].bw;
            p = int'(vecs[k].bw) + 1;
            v0 = vld_cnt;
            e0 = err_cnt;
            send_frame(vecs[k].data, p, vecs[k].stop_bit);
            repeat (2 * p + 8) @(negedge clk);
            chk($sformatf("v%0d vld", k), vld_cnt - v0, vecs[k].exp_vld);
            chk($sformatf("v%0d err", k), err_cnt - e0, vecs[k].exp_err);
            chk($sformatf("v%0d data", k), int'(rx_data),
                int'(vecs[k].exp_data));
            chk($sformatf("v%0d busy", k), int'(rx_busy), 0);
            if (vecs[k].exp_vld == 1) begin
                lat = t_vld - t_start - ((19 * p) / 2 + SYNC + 2);
                chk($sformatf("v%0d latency ok", k),
                    int'(lat >= -2 && lat <= 2), 1);
            end
        end

        // Stop bit low, then line held low for 100 bits (break)
        uart_bit_width = 16'd15;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 16, 1'b0);
        rx = 1'b0;
        repeat (100 * 16) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("break err", err_cnt - e0, 1);
        chk("break vld", vld_cnt - v0, 0);
        chk("break data kept", int'(rx_data), 8'h7E);
        chk("break busy", int'(rx_busy), 0);

        // Short glitch on the idle line, then a real frame
        v0 = vld_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch busy seen", int'(busy_seen), 1);
        chk("glitch busy clear", int'(rx_busy), 0);
        chk("glitch pulses", (vld_cnt - v0) + (err_cnt - e0), 0);
        send_frame(8'h5A, 16, 1'b1);
        repeat (40) @(negedge clk);
        chk("post-glitch vld", vld_cnt - v0, 1);
        chk("post-glitch data", int'(rx_data), 8'h5A);

        // Reset during bit 4 of a frame
        v0 = vld_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hA6 >> i) & 8'h01;
            repeat (16) @(negedge clk);
        end
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk("midrst data", int'(rx_data), 0);
        chk("midrst busy", int'(rx_busy), 0);
        chk("midrst vld", int'(rx_data_vld), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("midrst pulses", (vld_cnt - v0) + (err_cnt - e0), 0);
        send_frame(8'hC3, 16, 1'b1);
        repeat (40) @(negedge clk);
        chk("post-rst vld", vld_cnt - v0, 1);
        chk("post-rst data", int'(rx_data), 8'hC3);

        // Bit width change mid-frame, then a frame at the new width
        v0 = vld_cnt;
        uart_bit_width = 16'd15;
        fork
            send_frame(8'h96, 16, 1'b1);
            begin
                repeat (70) @(negedge clk);
                uart_bit_width = 16'd7;
            end
        join
        repeat (40) @(negedge clk);
        chk("bwchg vld", vld_cnt - v0, 1);
        chk("bwchg data", int'(rx_data), 8'h96);
        send_frame(8'h69, 8, 1'b1);
        repeat (24) @(negedge clk);
        chk("bw8 vld", vld_cnt - v0, 2);
        chk("bw8 data", int'(rx_data), 8'h69);

        // 256 back-to-back frames at 4 clk/bit
        uart_bit_width = 16'd3;
        rxq.delete();
        v0 = vld_cnt;
        e0 = err_cnt;
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 4, 1'b1);
        end
        repeat (20) @(negedge clk);
        chk("b2b count", vld_cnt - v0, 256);
        chk("b2b err", err_cnt - e0, 0);
        bad_data = 0;
        for (int b = 0; b < rxq.size() && b < 256; b++) begin
            if (rxq[b] != 8'(b)) bad_data++;
        end
        chk("b2b data order", bad_data, 0);

        chk("pulse rules", viol_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
